// File: rtl/aes_subbytes_seq.sv
// Sequential SubBytes front end that shares one combinational S-box across the 16 state bytes.
// Each byte uses two cycles. In SETUP the operands are registered. In EVAL they are presented
// on sbox_*_o, and the S-box result is written into the output buffers.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      input handshake; in_data/in_mask/masked_en are latched on transfer
//   seed_valid/seed        PRD LFSR load, honoured only while idle
//   sbox_en_o, sbox_*_o    shared S-box operands (all zero while sbox_en_o is low)
//   sbox_d_i, sbox_m_i     S-box result data and output mask
//   out_valid/out_ready    output handshake; out_data/out_mask are held from DONE onward
//   busy                   high in every state except IDLE
module aes_subbytes_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_mask,
   input  logic         masked_en,
   input  logic         seed_valid,
   input  logic [31:0]  seed,
   output logic         sbox_en_o,
   output logic [7:0]   sbox_d_o,
   output logic [7:0]   sbox_m_o,
   output logic [17:0]  sbox_prd_o,
   input  logic [7:0]   sbox_d_i,
   input  logic [7:0]   sbox_m_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [127:0] out_mask,
   output logic         busy
);

   localparam logic [31:0] LfsrTaps  = 32'h80200003;
   localparam logic [31:0] LfsrReset = 32'hACE10001;

   typedef enum logic [1:0] {StIdle, StSetup, StEval, StDone} state_e;

   state_e         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   mask_q, mask_d;
   logic           masked_q, masked_d;
   logic [31:0]    lfsr_q, lfsr_d;
   logic [127:0]   out_data_q, out_data_d;
   logic [127:0]   out_mask_q, out_mask_d;
   logic           sbox_en_q, sbox_en_d;
   logic [7:0]     sbox_d_q, sbox_d_d;
   logic [7:0]     sbox_m_q, sbox_m_d;
   logic [17:0]    sbox_prd_q, sbox_prd_d;
   logic [6:0]     byte_lsb;

   // Right-shifting Galois step: the bit shifted out selects the tap mask.
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? LfsrTaps : 32'h0);
   endfunction

   assign byte_lsb = {idx_q, 3'b000};

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      data_d     = data_q;
      mask_d     = mask_q;
      masked_d   = masked_q;
      lfsr_d     = lfsr_q;
      out_data_d = out_data_q;
      out_mask_d = out_mask_q;
      // The operand registers are non-zero only in the EVAL cycle that follows a SETUP.
      sbox_en_d  = 1'b0;
      sbox_d_d   = 8'h00;
      sbox_m_d   = 8'h00;
      sbox_prd_d = 18'h0;

      unique case (state_q)
         StIdle: begin
            // A seed load and a transfer can happen in the same cycle.
            // In that case byte 0 sees the fresh seed in SETUP.
            if (seed_valid) begin
               lfsr_d = (seed == 32'h0) ? 32'h00000001 : seed;
            end
            if (in_valid) begin
               data_d   = in_data;
               mask_d   = in_mask;
               masked_d = masked_en;
               idx_d    = 4'd0;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            sbox_en_d = 1'b1;
            sbox_d_d  = data_q[byte_lsb +: 8];
            if (masked_q) begin
               sbox_m_d   = mask_q[byte_lsb +: 8];
               sbox_prd_d = lfsr_q[17:0];
               lfsr_d     = lfsr_step(lfsr_q);
            end
            state_d = StEval;
         end
         StEval: begin
            out_data_d[byte_lsb +: 8] = sbox_d_i;
            out_mask_d[byte_lsb +: 8] = masked_q ? sbox_m_i : 8'h00;
            if (idx_q == 4'd15) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = StSetup;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         idx_q      <= 4'd0;
         data_q     <= 128'h0;
         mask_q     <= 128'h0;
         masked_q   <= 1'b0;
         lfsr_q     <= LfsrReset;
         out_data_q <= 128'h0;
         out_mask_q <= 128'h0;
         sbox_en_q  <= 1'b0;
         sbox_d_q   <= 8'h00;
         sbox_m_q   <= 8'h00;
         sbox_prd_q <= 18'h0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         masked_q   <= masked_d;
         lfsr_q     <= lfsr_d;
         out_data_q <= out_data_d;
         out_mask_q <= out_mask_d;
         sbox_en_q  <= sbox_en_d;
         sbox_d_q   <= sbox_d_d;
         sbox_m_q   <= sbox_m_d;
         sbox_prd_q <= sbox_prd_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign out_valid  = (state_q == StDone);
   assign out_data   = out_data_q;
   assign out_mask   = out_mask_q;
   assign sbox_en_o  = sbox_en_q;
   assign sbox_d_o   = sbox_d_q;
   assign sbox_m_o   = sbox_m_q;
   assign sbox_prd_o = sbox_prd_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq.
// A behavioural masked S-box is attached to the shared port. It computes
// S(d ^ m) ^ m', where m' is derived from the PRD value. Expected operands and outputs come
// from a reference model built on GF(2^8) arithmetic and a byte-level LFSR sequence.
module tb_aes_subbytes_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_mask;
   logic         masked_en;
   logic         seed_valid;
   logic [31:0]  seed;
   logic         sbox_en_o;
   logic [7:0]   sbox_d_o;
   logic [7:0]   sbox_m_o;
   logic [17:0]  sbox_prd_o;
   logic [7:0]   sbox_d_i;
   logic [7:0]   sbox_m_i;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [127:0] out_mask;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0]  model_lfsr;
   logic [33:0]  ops_q[$];

   always #5 clk = ~clk;

   aes_subbytes_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mask    (in_mask),
      .masked_en  (masked_en),
      .seed_valid (seed_valid),
      .seed       (seed),
      .sbox_en_o  (sbox_en_o),
      .sbox_d_o   (sbox_d_o),
      .sbox_m_o   (sbox_m_o),
      .sbox_prd_o (sbox_prd_o),
      .sbox_d_i   (sbox_d_i),
      .sbox_m_i   (sbox_m_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_mask   (out_mask),
      .busy       (busy)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] e = 8'hFE;
      logic [7:0] b;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (e[i]) r = gmul(r, x);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] model_step(input logic [31:0] l);
      logic [31:0] n = l >> 1;
      if (l[0]) n = n ^ 32'h80200003;
      return n;
   endfunction

   function automatic logic [7:0] remask(input logic [17:0] prd);
      return prd[7:0] ^ prd[17:10];
   endfunction

   // Behavioural masked S-box on the shared port.
   always_comb begin
      sbox_m_i = remask(sbox_prd_o);
      sbox_d_i = aes_sbox(sbox_d_o ^ sbox_m_o) ^ sbox_m_i;
   end

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Operand monitor: collects the operands of every S-box trigger and requires all-zero operands
   // otherwise.
   always @(negedge clk) begin
      if (sbox_en_o === 1'b1) begin
         ops_q.push_back({sbox_d_o, sbox_m_o, sbox_prd_o});
      end else begin
         check_eq("sbox_zero_when_idle", {94'h0, sbox_d_o, sbox_m_o, sbox_prd_o}, 128'h0);
      end
   end

   task automatic run_op(input logic [127:0] data, input logic [127:0] mask, input logic masked,
                         input logic do_seed, input logic [31:0] seed_val, input logic mid_seed,
                         input int bp);
      logic [127:0] exp_data;
      logic [127:0] exp_mask;
      logic [33:0]  exp_ops[16];
      logic [7:0]   d;
      logic [7:0]   m;
      logic [17:0]  prd;
      int           cycles;

      if (do_seed) model_lfsr = (seed_val == 32'h0) ? 32'h1 : seed_val;
      for (int k = 0; k < 16; k++) begin
         d   = data[k*8 +: 8];
         m   = masked ? mask[k*8 +: 8] : 8'h00;
         prd = masked ? model_lfsr[17:0] : 18'h0;
         if (masked) model_lfsr = model_step(model_lfsr);
         exp_ops[k]          = {d, m, prd};
         exp_data[k*8 +: 8]  = aes_sbox(d ^ m) ^ remask(prd);
         exp_mask[k*8 +: 8]  = masked ? remask(prd) : 8'h00;
      end

      ops_q.delete();
      @(negedge clk);
      check_eq("in_ready_idle", {127'h0, in_ready}, 128'h1);
      in_valid   = 1'b1;
      in_data    = data;
      in_mask    = mask;
      masked_en  = masked;
      seed_valid = do_seed;
      seed       = seed_val;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      seed_valid = 1'b0;
      in_data    = $urandom;
      check_eq("busy_after_xfer", {127'h0, busy}, 128'h1);

      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
         if (mid_seed && cycles == 4) begin
            seed_valid = 1'b1;
            seed       = $urandom;
         end
         if (cycles == 6) seed_valid = 1'b0;
      end
      check_eq("latency", 128'(cycles), 128'd32);
      check_eq("out_data", out_data, exp_data);
      check_eq("out_mask", out_mask, exp_mask);
      check_eq("n_triggers", 128'(ops_q.size()), 128'd16);
      for (int k = 0; k < 16 && k < ops_q.size(); k++) begin
         check_eq($sformatf("operands_b%0d", k), {94'h0, ops_q[k]}, {94'h0, exp_ops[k]});
      end

      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         #1;
         check_eq("bp_valid", {126'h0, out_valid, in_ready}, 128'h2);
         check_eq("bp_data", out_data ^ out_mask, exp_data ^ exp_mask);
      end

      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("idle_after_ack", {125'h0, in_ready, out_valid, busy}, 128'h4);
      check_eq("held_data", out_data, exp_data);
      check_eq("held_mask", out_mask, exp_mask);
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] m;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_mask    = '0;
      masked_en  = 1'b0;
      seed_valid = 1'b0;
      seed       = '0;
      out_ready  = 1'b0;
      model_lfsr = 32'hACE10001;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_ctrl", {125'h0, in_ready, out_valid, busy}, 128'h4);
      check_eq("reset_data", out_data, 128'h0);
      check_eq("reset_mask", out_mask, 128'h0);
      check_eq("reset_sbox", {94'h0, sbox_d_o, sbox_m_o, sbox_prd_o}, {127'h0, sbox_en_o});
      rst_n = 1'b1;

      // All-zero state, unmasked.
      run_op(128'h0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 32'h0, 1'b0, 0);
      check_eq("zero_vec", out_data, {16{8'h63}});

      // Known-answer byte 0x53 -> 0xED.
      run_op(128'h53, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2);
      check_eq("kat_53", out_data, {{15{8'h63}}, 8'hED});

      // Masked with explicit seed, long backpressure.
      d = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      run_op(d, m, 1'b1, 1'b1, 32'h12345678, 1'b0, 10);
      for (int k = 0; k < 16; k++) begin
         check_eq($sformatf("unmasked_b%0d", k), 128'((out_data ^ out_mask) >> (k * 8)) & 128'hFF,
                  128'(aes_sbox(d[k*8 +: 8] ^ m[k*8 +: 8])));
      end

      // Zero seed loads 1; seed_valid mid-operation is ignored.
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'b1, 1'b1, 32'h0, 1'b0, 1);
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'b1, 1'b0, 32'h0, 1'b1, 0);

      // Reset while evaluating byte 7.
      d = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_mask   = {$urandom, $urandom, $urandom, $urandom};
      masked_en = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check_eq("byte7_eval", {119'h0, sbox_en_o, sbox_d_o}, {119'h0, 1'b1, d[63:56]});
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("abort_ctrl", {124'h0, in_ready, out_valid, busy, sbox_en_o}, 128'h8);
      check_eq("abort_data", out_data | out_mask, 128'h0);
      model_lfsr = 32'hACE10001;
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'b1, 1'b0, 32'h0, 1'b0, 0);

      // Random mix.
      for (int i = 0; i < 6; i++) begin
         run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                1'($urandom), $urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
